cellram_async_ctl: RTL and testbench

CELLRAM_ASYNC_CTL -- requirements
Module: cellram_async_ctl

---
 rtl/cellram_pkg.sv | 44 ++++
 rtl/cellram_timer.sv | 28 ++
 rtl/cellram_async_ctl.sv | 206 ++++++++++++++++++++
 tb/tb_cellram_async_ctl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cellram_pkg.sv
// Shared state encoding, pin constants and helpers for the CellularRAM async controller.
package cellram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE,
      ST_RECOVER
   } state_t;

   typedef struct packed {
      logic nce;
      logic nadv;
      logic noe;
      logic nwe;
      logic nlb;
      logic nub;
   } pins_t;

   // Everything released: chip deselected, strobes high, no byte lanes.
   localparam pins_t PINS_IDLE = 6'b111111;
   // Chip still selected while bus_ready is presented, all strobes released.
   localparam pins_t PINS_HOLD = 6'b011111;

   localparam int TMR_W = 6;

   function automatic pins_t setup_pins(input logic wr, input logic [3:0] be, input logic h);
      pins_t p;
      p.nce  = 1'b0;
      p.nadv = 1'b0;
      p.noe  = wr;
      p.nwe  = 1'b1;
      if (wr) begin
         p.nlb = h ? ~be[2] : ~be[0];
         p.nub = h ? ~be[3] : ~be[1];
      end else begin
         p.nlb = 1'b0;
         p.nub = 1'b0;
      end
      return p;
   endfunction

endpackage

// File: rtl/cellram_timer.sv
// Loadable down-counter with zero flag; paces both ACCESS and RECOVER.
module cellram_timer
   import cellram_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/cellram_async_ctl.sv
// Asynchronous CellularRAM controller bridging a 32-bit bus request to 16-bit memory cycles.
// Define CELLRAM_WIDE32_EN to split 32-bit accesses into two 16-bit halves.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a decoded request; pins released
// ST_SETUP   | address/nCE/nADV (and nOE or write data) presented, 1 cycle
// ST_ACCESS  | nOE or nWE active for RD_WAIT / WR_WAIT cycles
// ST_DONE    | bus_ready high for one cycle, captured data on bus_rdata
// ST_RECOVER | nCE high before the next access may start
module cellram_async_ctl
   import cellram_pkg::*;
#(
   parameter logic [7:0] BASE_HI = 8'h80,
   parameter int         RD_WAIT = 6,
   parameter int         WR_WAIT = 6,
   parameter int         RECOV   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic [3:0]  bus_be,
   input  logic        bus_rd,
   input  logic        bus_wr,
   output logic [31:0] bus_rdata,
   output logic        bus_ready,
   output logic        cr_nADV,
   output logic        cr_nCE,
   output logic        cr_nOE,
   output logic        cr_nWE,
   output logic        cr_CRE,
   output logic        cr_nLB,
   output logic        cr_nUB,
   output logic        cr_CLK,
   output logic        st_nCE,
   output logic [22:0] cr_A,
   inout  wire  [15:0] cr_DQ
);

`ifdef CELLRAM_WIDE32_EN
   localparam logic WIDE = 1'b1;
`else
   localparam logic WIDE = 1'b0;
`endif

   localparam logic [TMR_W-1:0] RD_LOAD  = TMR_W'(RD_WAIT - 1);
   localparam logic [TMR_W-1:0] WR_LOAD  = TMR_W'(WR_WAIT - 1);
   // The mandatory IDLE cycle is the last nCE-high cycle, so RECOVER spans RECOV-1 cycles.
   localparam logic [TMR_W-1:0] REC_LOAD = (RECOV > 1) ? TMR_W'(RECOV - 2) : '0;
   localparam state_t           ST_AFTER = (RECOV > 1) ? ST_RECOVER : ST_IDLE;

   state_t            state;
   pins_t             pins;
   logic              half;
   logic              is_wr;
   logic              abort_q;
   logic [31:0]       addr_q;
   logic [31:0]       rdata_q;
   logic [31:0]       rd_next;
   logic              dq_oe;
   logic [15:0]       dq_out;
   logic              hit;
   logic              req_lost;
   logic              wr_none;
   logic              start_half;
   logic              more_half;
   logic              tmr_load;
   logic              tmr_zero;
   logic [TMR_W-1:0]  tmr_val;

   function automatic logic [22:0] a_map(input logic [31:0] a, input logic h);
      return WIDE ? {a[23:2], h} : a[23:1];
   endfunction

   assign hit        = (bus_addr[31:24] == BASE_HI) && (bus_rd || bus_wr);
   assign req_lost   = !(bus_rd || bus_wr) || (bus_addr != addr_q);
   assign wr_none    = (bus_be[1:0] == 2'b00) && (!WIDE || (bus_be[3:2] == 2'b00));
   assign start_half = WIDE && bus_wr && (bus_be[1:0] == 2'b00);
   assign more_half  = WIDE && !half && (!is_wr || (bus_be[3:2] != 2'b00));
   assign rd_next    = half ? {cr_DQ, rdata_q[15:0]}
                            : {(WIDE ? rdata_q[31:16] : 16'h0000), cr_DQ};

   always_comb begin
      tmr_load = 1'b1;
      tmr_val  = REC_LOAD;
      if (state == ST_SETUP && !req_lost) begin
         tmr_val = is_wr ? WR_LOAD : RD_LOAD;
      end else if (state == ST_ACCESS && !tmr_zero && !(req_lost && !is_wr)) begin
         tmr_load = 1'b0;
      end else if (state == ST_RECOVER) begin
         tmr_load = 1'b0;
      end
   end

   cellram_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pins      <= PINS_IDLE;
         half      <= 1'b0;
         is_wr     <= 1'b0;
         abort_q   <= 1'b0;
         addr_q    <= '0;
         rdata_q   <= '0;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
         cr_A      <= '0;
         bus_ready <= 1'b0;
         bus_rdata <= '0;
      end else begin
         bus_ready <= 1'b0;
         bus_rdata <= '0;
         case (state)
            ST_IDLE: begin
               if (hit) begin
                  addr_q  <= bus_addr;
                  is_wr   <= bus_wr;
                  abort_q <= 1'b0;
                  rdata_q <= '0;
                  if (bus_wr && wr_none) begin
                     state     <= ST_DONE;
                     bus_ready <= 1'b1;
                  end else begin
                     state  <= ST_SETUP;
                     half   <= start_half;
                     pins   <= setup_pins(bus_wr, bus_be, start_half);
                     cr_A   <= a_map(bus_addr, start_half);
                     dq_oe  <= bus_wr;
                     dq_out <= start_half ? bus_wdata[31:16] : bus_wdata[15:0];
                  end
               end
            end
            ST_SETUP: begin
               if (req_lost) begin
                  state <= ST_AFTER;
                  pins  <= PINS_IDLE;
                  dq_oe <= 1'b0;
               end else begin
                  state <= ST_ACCESS;
                  if (is_wr) pins.nwe <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (!is_wr && req_lost) begin
                  state <= ST_AFTER;
                  pins  <= PINS_IDLE;
               end else if (tmr_zero) begin
                  if (!is_wr) rdata_q <= rd_next;
                  if (req_lost || abort_q) begin
                     state <= ST_AFTER;
                     pins  <= PINS_IDLE;
                     dq_oe <= 1'b0;
                  end else if (more_half) begin
                     state  <= ST_SETUP;
                     half   <= 1'b1;
                     pins   <= setup_pins(is_wr, bus_be, 1'b1);
                     cr_A   <= a_map(addr_q, 1'b1);
                     dq_out <= bus_wdata[31:16];
                  end else begin
                     state     <= ST_DONE;
                     pins      <= PINS_HOLD;
                     dq_oe     <= 1'b0;
                     bus_ready <= 1'b1;
                     bus_rdata <= is_wr ? 32'h0 : rd_next;
                  end
               end else if (req_lost) begin
                  // A write keeps its nWE pulse intact and leaves at the end of this half.
                  abort_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_AFTER;
               pins  <= PINS_IDLE;
            end
            ST_RECOVER: begin
               if (tmr_zero) state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               pins  <= PINS_IDLE;
               dq_oe <= 1'b0;
            end
         endcase
      end
   end

   assign cr_nCE  = pins.nce;
   assign cr_nADV = pins.nadv;
   assign cr_nOE  = pins.noe;
   assign cr_nWE  = pins.nwe;
   assign cr_nLB  = pins.nlb;
   assign cr_nUB  = pins.nub;
   assign cr_CRE  = 1'b0;
   assign cr_CLK  = 1'b0;
   assign st_nCE  = 1'b0;
   assign cr_DQ   = dq_oe ? dq_out : 16'hzzzz;

endmodule

// File: tb/tb_cellram_async_ctl.sv
// Directed, table-driven bench for cellram_async_ctl with a simple CellularRAM read model.
module tb_cellram_async_ctl;

`ifdef CELLRAM_WIDE32_EN
   localparam bit WIDE = 1'b1;
`else
   localparam bit WIDE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] bus_addr = '0;
   logic [31:0] bus_wdata = '0;
   logic [3:0]  bus_be = '0;
   logic        bus_rd = 1'b0;
   logic        bus_wr = 1'b0;
   logic [31:0] bus_rdata;
   logic        bus_ready;
   logic        cr_nADV, cr_nCE, cr_nOE, cr_nWE, cr_CRE, cr_nLB, cr_nUB, cr_CLK, st_nCE;
   logic [22:0] cr_A;
   wire  [15:0] dq;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cellram_async_ctl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_be    (bus_be),
      .bus_rd    (bus_rd),
      .bus_wr    (bus_wr),
      .bus_rdata (bus_rdata),
      .bus_ready (bus_ready),
      .cr_nADV   (cr_nADV),
      .cr_nCE    (cr_nCE),
      .cr_nOE    (cr_nOE),
      .cr_nWE    (cr_nWE),
      .cr_CRE    (cr_CRE),
      .cr_nLB    (cr_nLB),
      .cr_nUB    (cr_nUB),
      .cr_CLK    (cr_CLK),
      .st_nCE    (st_nCE),
      .cr_A      (cr_A),
      .cr_DQ     (dq)
   );

   function automatic logic [15:0] mem_rd(input logic [22:0] a);
      if (a == 23'd0) return 16'h1234;
      if (a == 23'd1) return 16'hABCD;
      return a[15:0] ^ 16'h5A5A;
   endfunction

   assign dq = (!cr_nCE && !cr_nOE) ? mem_rd(cr_A) : 16'hzzzz;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        rd;
      logic        wr;
      logic        exp_ready;
      int          exp_lat;
      logic [31:0] exp_rdata;
      int          exp_pulses;
      int          exp_plen;
      logic [22:0] exp_a;
      logic [15:0] exp_dq;
      logic        exp_lb;
      logic        exp_ub;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                               input logic rd, input logic wr, input logic rdy, input int lat,
                               input logic [31:0] rdata, input int pulses, input logic [22:0] a,
                               input logic [15:0] d, input logic lb, input logic ub);
      vec_t v;
      v.addr = addr; v.wdata = wdata; v.be = be; v.rd = rd; v.wr = wr;
      v.exp_ready = rdy; v.exp_lat = lat; v.exp_rdata = rdata; v.exp_pulses = pulses;
      v.exp_plen = 6; v.exp_a = a; v.exp_dq = d; v.exp_lb = lb; v.exp_ub = ub;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_ready(input int budget, output logic got, output int lat, output logic [31:0] rdata);
      got = 1'b0; lat = 0; rdata = '0;
      for (int c = 1; c <= budget && !got; c++) begin
         @(posedge clk); #1;
         if (bus_ready) begin
            got = 1'b1; lat = c; rdata = bus_rdata;
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      bus_rd = 1'b0; bus_wr = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int cyc, lat, pulses, plen, nce_low, rd_nz, extra;
      logic got, prev_we, llb, lub;
      logic [31:0] rdata;
      logic [22:0] la;
      logic [15:0] ldq;
      cyc = 0; lat = 0; pulses = 0; plen = 0; nce_low = 0; rd_nz = 0; extra = 0;
      got = 1'b0; prev_we = 1'b1; llb = 1'b1; lub = 1'b1; rdata = '0; la = '0; ldq = '0;
      bus_addr = v.addr; bus_wdata = v.wdata; bus_be = v.be; bus_rd = v.rd; bus_wr = v.wr;
      while (!got && cyc < 40) begin
         @(posedge clk); #1; cyc++;
         if (!cr_nCE) nce_low++;
         if (!cr_nWE) begin
            if (prev_we) begin pulses++; plen = 0; end
            plen++; la = cr_A; ldq = dq; llb = cr_nLB; lub = cr_nUB;
         end
         prev_we = cr_nWE;
         if (bus_ready) begin got = 1'b1; lat = cyc; rdata = bus_rdata; end
         else if (bus_rdata != 32'h0) rd_nz++;
      end
      bus_rd = 1'b0; bus_wr = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus_ready) extra++;
         if (bus_rdata != 32'h0) rd_nz++;
      end
      check($sformatf("v%0d_ready", idx), {31'h0, got}, {31'h0, v.exp_ready});
      check($sformatf("v%0d_rdata_idle_zero", idx), rd_nz, 0);
      check($sformatf("v%0d_single_ready", idx), extra, 0);
      check($sformatf("v%0d_we_pulses", idx), pulses, v.exp_pulses);
      if (v.exp_ready) begin
         check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
         check($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
      end else begin
         check($sformatf("v%0d_nce_low_cycles", idx), nce_low, 0);
      end
      if (v.exp_pulses > 0) begin
         check($sformatf("v%0d_we_len", idx), plen, v.exp_plen);
         check($sformatf("v%0d_addr", idx), {9'h0, la}, {9'h0, v.exp_a});
         check($sformatf("v%0d_dq", idx), {16'h0, ldq}, {16'h0, v.exp_dq});
         check($sformatf("v%0d_nlb", idx), {31'h0, llb}, {31'h0, v.exp_lb});
         check($sformatf("v%0d_nub", idx), {31'h0, lub}, {31'h0, v.exp_ub});
      end
   endtask

   initial begin
      logic        got;
      int          lat, hi;
      logic [31:0] rdata;

      vecs[0] = mk(32'h8000_0000, 32'h0, 4'b0000, 1, 0, 1, WIDE ? 15 : 8,
                   WIDE ? 32'hABCD_1234 : 32'h0000_1234, 0, 23'h0, 16'h0, 1, 1);
      vecs[1] = mk(32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 0, 1, 1, 8, 32'h0, 1, 23'h000008, 16'hBEEF, 0, 0);
      vecs[2] = mk(32'h4000_0000, 32'h0, 4'b0000, 1, 0, 0, 0, 32'h0, 0, 23'h0, 16'h0, 1, 1);
      vecs[3] = mk(32'h8000_0104, 32'h0, 4'b0000, 1, 0, 1, WIDE ? 15 : 8,
                   WIDE ? 32'h5AD9_5AD8 : 32'h0000_5AD8, 0, 23'h0, 16'h0, 1, 1);
      vecs[4] = WIDE ? mk(32'h8000_0020, 32'hCAFE_F00D, 4'b1100, 0, 1, 1, 8, 32'h0, 1, 23'h000011, 16'hCAFE, 0, 0)
                     : mk(32'h8000_0020, 32'hCAFE_F00D, 4'b1100, 0, 1, 1, 1, 32'h0, 0, 23'h0, 16'h0, 1, 1);
      vecs[5] = WIDE ? mk(32'h8000_0030, 32'h1357_2468, 4'b1111, 0, 1, 1, 15, 32'h0, 2, 23'h000019, 16'h1357, 0, 0)
                     : mk(32'h8000_0030, 32'h1357_2468, 4'b1111, 0, 1, 1, 8, 32'h0, 1, 23'h000018, 16'h2468, 0, 0);
      vecs[6] = mk(32'h8000_0040, 32'h0000_55AA, 4'b0001, 0, 1, 1, 8, 32'h0, 1, 23'h000020, 16'h55AA, 0, 1);
      vecs[7] = mk(32'h8000_0050, 32'h0000_77EE, 4'b0010, 1, 1, 1, 8, 32'h0, 1, 23'h000028, 16'h77EE, 1, 0);
      vecs[8] = mk(32'h8000_0060, 32'hFFFF_FFFF, 4'b0000, 0, 1, 1, 1, 32'h0, 0, 23'h0, 16'h0, 1, 1);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_nce", {31'h0, cr_nCE}, 32'h1);
      check("rst_noe_nwe_nadv", {29'h0, cr_nOE, cr_nWE, cr_nADV}, 32'h7);
      check("rst_nlb_nub", {30'h0, cr_nLB, cr_nUB}, 32'h3);
      check("rst_dq_z", {31'h0, (dq === 16'hzzzz)}, 32'h1);
      check("rst_ready", {31'h0, bus_ready}, 32'h0);
      check("rst_rdata", bus_rdata, 32'h0);
      check("tie_cre_clk_stnce", {29'h0, cr_CRE, cr_CLK, st_nCE}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // back-to-back reads
      bus_addr = 32'h8000_0000; bus_rd = 1'b1;
      wait_ready(40, got, lat, rdata);
      check("b2b_first_ready", {31'h0, got}, 32'h1);
      bus_addr = 32'h8000_0008;
      hi = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (cr_nCE) hi++;
         else if (hi > 0) break;
      end
      check("b2b_nce_high_cycles", hi, 2);
      wait_ready(40, got, lat, rdata);
      check("b2b_second_ready", {31'h0, got}, 32'h1);
      check("b2b_second_rdata", rdata, WIDE ? 32'h5A5F_5A5E : 32'h0000_5A5E);
      idle_cycles(6);

      // request dropped in the third ACCESS cycle
      bus_addr = 32'h8000_0000; bus_rd = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("abort_pre_nce", {31'h0, cr_nCE}, 32'h0);
      bus_rd = 1'b0;
      @(posedge clk); #1;
      check("abort_nce_high", {31'h0, cr_nCE}, 32'h1);
      check("abort_noe_high", {31'h0, cr_nOE}, 32'h1);
      hi = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus_ready || bus_rdata != 32'h0) hi++;
      end
      check("abort_no_ready", hi, 0);
      bus_rd = 1'b1;
      wait_ready(40, got, lat, rdata);
      check("abort_recover_latency", lat, WIDE ? 15 : 8);
      check("abort_recover_rdata", rdata, WIDE ? 32'hABCD_1234 : 32'h0000_1234);
      idle_cycles(6);

      // reset during write ACCESS
      bus_addr = 32'h8000_0030; bus_wdata = 32'h1357_2468; bus_be = 4'b1111; bus_wr = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rstw_pre_nwe", {31'h0, cr_nWE}, 32'h0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rstw_nwe", {31'h0, cr_nWE}, 32'h1);
      check("rstw_dq_z", {31'h0, (dq === 16'hzzzz)}, 32'h1);
      check("rstw_ready", {31'h0, bus_ready}, 32'h0);
      check("rstw_nce", {31'h0, cr_nCE}, 32'h1);
      rst_n = 1'b1; bus_wr = 1'b0;
      @(posedge clk); #1;
      bus_addr = 32'h8000_0000; bus_rd = 1'b1;
      wait_ready(40, got, lat, rdata);
      check("rstw_idle_latency", lat, WIDE ? 15 : 8);
      idle_cycles(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
